flex_down_counter: RTL and testbench
====================================

Name: flex_down_counter

Overview:
- Loadable down-counter/timer; the decrementing counterpart to the team's rollover up-counter.
- Software or an upstream FSM loads a period; the block counts down on `count_enable` and reports terminal count with a one-cycle `done_pulse`.
- Used by the corner-detector control path for pixel/row countdowns and periodic ticks (auto-reload mode).
- Three-state FSM (IDLE/RUN/DONE) with a reload register.

Parameters:
- SIZE, 4, width in bits of the count, load value and reload register.

Ports:
- clk  input  1  system clock, rising-edge, max 100 MHz
- n_rst  input  1  asynchronous, active-low reset
- clear  input  1  synchronous active-high abort; returns to IDLE
- load  input  1  synchronous active-high; captures load_val and starts a countdown
- load_val  input  SIZE  countdown period (number of enabled cycles to terminal)
- count_enable  input  1  active-high decrement enable
- auto_reload  input  1  1 = reload the period at terminal and keep running; 0 = one-shot
- count_out  output  SIZE  current count value, registered
- busy  output  1  high while in RUN, registered
- zero_flag  output  1  high while in DONE (one-shot expired), registered
- done_pulse  output  1  one-cycle pulse on each terminal count, registered

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE, count_out=0, reload_reg=0.
  - busy=0, zero_flag=0, done_pulse=0.
- Priority per clock edge: clear > load > count_enable.
- done_pulse defaults to 0 every cycle; it is set only by the terminal event below.
- clear=1 (any state):
  - count_out=0, state=IDLE, busy=0, zero_flag=0, done_pulse=0.
  - reload_reg is unchanged.
- load=1 (any state, clear=0):
  - reload_reg=load_val, count_out=load_val, zero_flag=0, done_pulse=0.
  - load_val!=0: state=RUN, busy=1 from the next cycle.
  - load_val==0: state=IDLE, busy=0; no done_pulse (a zero period is treated as no-op).
  - A load during RUN restarts the countdown; a load during DONE re-arms.
- IDLE: count_enable ignored; count_out holds.
- RUN, count_enable=0: all state holds.
- RUN, count_enable=1, count_out>1: count_out decrements by 1.
- RUN, count_enable=1, count_out==1 (terminal event):
  - done_pulse=1 for exactly one cycle.
  - auto_reload=1: count_out=reload_reg, stay in RUN (period = reload_reg enabled cycles).
  - auto_reload=0: count_out=0, state=DONE, busy=0, zero_flag=1.
  - auto_reload is sampled only in the terminal cycle.
- DONE: count_enable ignored. count_out=0 and zero_flag=1 hold until load or clear.
- Latency: done_pulse appears on the same edge at which count_out would leave 1, i.e. N enabled cycles after a load of N.
- Terminal and load in the same cycle: load wins; no done_pulse.
- Terminal and clear in the same cycle: clear wins; no done_pulse.
- Arithmetic: unsigned SIZE-bit.
  - In RUN, count_out never wraps below 0; the defensive case count_out==0 in RUN is treated as terminal.
  - Maximum period is 2^SIZE-1.
- Reset mid-RUN: immediate return to reset values; reload_reg is lost.

Optional Feature:
- Macro: FLEX_DOWN_COUNTER_EVENT_CNT_EN
- Defined:
  - Adds output `event_cnt [SIZE-1:0]`, reset 0, cleared by clear or load.
  - Increments on every done_pulse and saturates at 2^SIZE-1 (no wrap).
  - Intended for counting auto-reload periods.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold n_rst=0 mid-stimulus -> all outputs 0 asynchronously. Release, then pulse count_enable -> count_out stays 0, busy=0.
- One-shot: load_val=5, load=1, then count_enable held high -> count_out 5,4,3,2,1,0. done_pulse=1 only on the 1->0 edge; then zero_flag=1, busy=0. Further enables keep count_out=0.
- Auto-reload with gaps: load_val=3, auto_reload=1, count_enable toggling 1/0 -> count_out 3,2,1,3,2,1,... advancing only on enabled cycles. done_pulse every 3rd enabled cycle; busy stays 1.
- Priority: at count_out=1 with count_enable=1, assert load=1 with load_val=7 -> count_out=7, no done_pulse. Repeat with clear=1 -> count_out=0, IDLE, no done_pulse.
- Zero and max load: load_val=0 -> IDLE, busy=0, zero_flag=0, no pulse. load_val=15 (SIZE=4) -> exactly 15 enabled cycles to done_pulse.
- Optional (macro defined, SIZE=4): load_val=1 with auto_reload=1 for 20 enabled cycles -> event_cnt saturates at 15. Subsequent load -> event_cnt=0.

Source files
------------

// File: rtl/flex_down_counter.sv
// flex_down_counter: loadable down-counter/timer with one-shot or auto-reload terminal count.
// Define FLEX_DOWN_COUNTER_EVENT_CNT_EN to add the saturating event_cnt output.
module flex_down_counter #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            clear,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            count_enable,
  input  logic            auto_reload,
  output logic [SIZE-1:0] count_out,
  output logic            busy,
  output logic            zero_flag,
  output logic            done_pulse
`ifdef FLEX_DOWN_COUNTER_EVENT_CNT_EN
  ,output logic [SIZE-1:0] event_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q;
  logic [SIZE-1:0] count_q, reload_q, ev_q;
  logic busy_q, zero_q, done_q;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      ev_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        count_q <= '0;
        busy_q  <= 1'b0;
        zero_q  <= 1'b0;
        ev_q    <= '0;
      end else if (load) begin
        reload_q <= load_val;
        count_q  <= load_val;
        zero_q   <= 1'b0;
        busy_q   <= load_val != '0;
        state_q  <= load_val != '0 ? RUN : IDLE;
        ev_q     <= '0;
      end else if (state_q == RUN && count_enable) begin
        if (count_q > SIZE'(1))
          count_q <= count_q - SIZE'(1);
        else begin
          // count_q==0 in RUN cannot normally occur; treating it as terminal prevents wrap
          done_q <= 1'b1;
          ev_q   <= ev_q != '1 ? ev_q + SIZE'(1) : ev_q;
          if (auto_reload)
            count_q <= reload_q;
          else begin
            count_q <= '0;
            state_q <= DONE;
            busy_q  <= 1'b0;
            zero_q  <= 1'b1;
          end
        end
      end
    end
  assign count_out  = count_q;
  assign busy       = busy_q;
  assign zero_flag  = zero_q;
  assign done_pulse = done_q;
`ifdef FLEX_DOWN_COUNTER_EVENT_CNT_EN
  assign event_cnt = ev_q;
`else
  logic unused_ev;
  assign unused_ev = ^ev_q;
`endif
endmodule

// File: tb/tb_flex_down_counter.sv
// tb_flex_down_counter: directed vectors feed an expected-value queue; a monitor pops and compares each cycle.
module tb_flex_down_counter;
  logic clk = 1'b0, n_rst = 1'b0, clear = 1'b0, load = 1'b0, count_enable = 1'b0, auto_reload = 1'b0;
  logic [3:0] load_val = '0, count_out;
  logic busy, zero_flag, done_pulse;
`ifdef FLEX_DOWN_COUNTER_EVENT_CNT_EN
  logic [3:0] event_cnt;
`endif
  int checks = 0, errors = 0, vec = 0;
  typedef struct {logic [6:0] o; int ev; int idx;} exp_t;
  exp_t exp_q[$];

  flex_down_counter #(.SIZE(4)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .auto_reload(auto_reload), .count_out(count_out),
    .busy(busy), .zero_flag(zero_flag), .done_pulse(done_pulse)
`ifdef FLEX_DOWN_COUNTER_EVENT_CNT_EN
    ,.event_cnt(event_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input logic c, l, input logic [3:0] lv, input logic en, ar,
                      input logic [3:0] ec, input logic eb, ez, ed, input int ev = -1);
    exp_t e;
    @(negedge clk);
    clear = c; load = l; load_val = lv; count_enable = en; auto_reload = ar;
    e.o = {ec, eb, ez, ed}; e.ev = ev; e.idx = vec++;
    exp_q.push_back(e);
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({count_out, busy, zero_flag, done_pulse} !== e.o) begin
        errors++;
        $display("FAIL vec%0d {count,busy,zero,done} got %h/%b/%b/%b want %h/%b/%b/%b", e.idx,
                 count_out, busy, zero_flag, done_pulse, e.o[6:3], e.o[2], e.o[1], e.o[0]);
      end
`ifdef FLEX_DOWN_COUNTER_EVENT_CNT_EN
      if (e.ev >= 0) begin
        checks++;
        if (int'(event_cnt) != e.ev) begin
          errors++;
          $display("FAIL vec%0d event_cnt got %0d want %0d", e.idx, event_cnt, e.ev);
        end
      end
`endif
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if ({count_out, busy, zero_flag, done_pulse} !== 7'd0) begin
      errors++;
      $display("FAIL %s outputs got %h/%b/%b/%b want 0/0/0/0", name, count_out, busy, zero_flag, done_pulse);
    end
  endtask

  initial begin
    #12 check_zero("reset_initial");
    @(negedge clk); n_rst = 1'b1;
    step(0,0,0,1,0, 0,0,0,0);
    step(0,0,0,1,0, 0,0,0,0);
    // one-shot of 5
    step(0,1,5,0,0, 5,1,0,0);
    for (int i = 4; i >= 1; i--) step(0,0,0,1,0, 4'(i),1,0,0);
    step(0,0,0,1,0, 0,0,1,1);
    step(0,0,0,1,0, 0,0,1,0);
    step(0,0,0,1,0, 0,0,1,0);
    // auto-reload of 3 with enable gaps; load from DONE re-arms
    step(0,1,3,0,1, 3,1,0,0);
    step(0,0,0,1,1, 2,1,0,0);
    step(0,0,0,0,1, 2,1,0,0);
    step(0,0,0,1,1, 1,1,0,0);
    step(0,0,0,0,1, 1,1,0,0);
    step(0,0,0,1,1, 3,1,0,1);
    step(0,0,0,0,1, 3,1,0,0);
    step(0,0,0,1,1, 2,1,0,0);
    step(0,0,0,1,1, 1,1,0,0);
    step(0,0,0,1,1, 3,1,0,1);
    // load beats terminal
    step(0,0,0,1,1, 2,1,0,0);
    step(0,0,0,1,1, 1,1,0,0);
    step(0,1,7,1,1, 7,1,0,0);
    for (int i = 6; i >= 1; i--) step(0,0,0,1,0, 4'(i),1,0,0);
    // clear beats terminal and load
    step(1,1,9,1,0, 0,0,0,0);
    step(0,0,0,1,0, 0,0,0,0);
    // zero load is a no-op
    step(0,1,0,1,1, 0,0,0,0);
    step(0,0,0,1,1, 0,0,0,0);
    // max period: 15 enabled cycles
    step(0,1,15,0,0, 15,1,0,0);
    for (int i = 14; i >= 1; i--) step(0,0,0,1,0, 4'(i),1,0,0);
    step(0,0,0,1,0, 0,0,1,1);
    // async reset mid-run
    step(0,1,9,0,0, 9,1,0,0);
    step(0,0,0,1,0, 8,1,0,0);
    @(posedge clk); #3;
    n_rst = 1'b0;
    #1 check_zero("reset_async");
    @(posedge clk); #1 check_zero("reset_held");
    @(negedge clk); n_rst = 1'b1;
    step(0,0,0,1,1, 0,0,0,0);
    step(0,0,0,1,1, 0,0,0,0);
`ifdef FLEX_DOWN_COUNTER_EVENT_CNT_EN
    step(1,0,0,0,0, 0,0,0,0, 0);
    step(0,1,1,0,1, 1,1,0,0, 0);
    for (int i = 1; i <= 20; i++) step(0,0,0,1,1, 1,1,0,1, i > 15 ? 15 : i);
    step(0,1,4,0,0, 4,1,0,0, 0);
    step(0,0,0,1,0, 3,1,0,0, 0);
`endif
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
